// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file storage slice.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd31;

    // A write is accepted only when enabled and not aimed at the zero register.
    function automatic logic write_accepted(input logic en, input reg_addr_t addr);
        return en && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Write port and transposed column bus of the register-file storage stage.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
);

    logic                             wr_en;
    reg_addr_t                        wr_addr;
    logic [WIDTH-1:0]                 wr_data;
    logic [WIDTH-1:0][NUM_REGS-1:0]   columns;
    logic                             wr_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  columns,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output columns,
        output wr_ack
    );

endinterface

// File: rtl/decoder_5to32.sv
// Enabled 5:32 one-hot decoder, built as a 2:4 stage feeding four 3:8 stages
// in the same shape as the downstream hierarchical read-mux tree.
module dec2to4 (
    input  logic       en,
    input  logic [1:0] a,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end

endmodule

module dec3to8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end

endmodule

module decoder_5to32
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] sel
);

    logic [3:0] grp;

    dec2to4 u_hi (
        .en (en),
        .a  (addr[4:3]),
        .y  (grp)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lo
        dec3to8 u_lo (
            .en (grp[g]),
            .a  (addr[2:0]),
            .y  (sel[g*8 +: 8])
        );
    end

endmodule

// File: rtl/regfile_array.sv
// Storage stage of the register file: 31 writable registers plus a hardwired
// zero register, presented bit-transposed so each read mux gets one column.
module regfile_array
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
)(
    input  logic      clk,
    input  logic      reset_n,
    regfile_if.slave  bus
);

    logic [NUM_REGS-1:0]            wr_sel;
    logic [NUM_REGS-1:0][WIDTH-1:0] words;
    logic                           sel_unused;

    decoder_5to32 u_dec (
        .en   (bus.wr_en),
        .addr (bus.wr_addr),
        .sel  (wr_sel)
    );

    // Register 31 has no storage, so its select line goes nowhere.
    assign sel_unused = wr_sel[ZERO_REG];

    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q;

        assign d = wr_sel[r] ? bus.wr_data : q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) q <= '0;
            else          q <= d;
        end

        assign words[r] = q;
    end

    assign words[ZERO_REG] = '0;

    for (genvar b = 0; b < WIDTH; b++) begin : g_col
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_bit
            assign bus.columns[b][r] = words[r][b];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.wr_ack <= 1'b0;
        else          bus.wr_ack <= write_accepted(bus.wr_en, bus.wr_addr);
    end

endmodule

// File: tb/tb_regfile_array.sv
// Randomized self-checking bench for regfile_array against an array-based model.
module tb_regfile_array;

    localparam int unsigned W = 64;

    logic clk;
    logic reset_n;

    regfile_if #(.WIDTH(W)) bus ();

    regfile_array #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_vec;
    int unsigned n_err;

    logic [W-1:0] model [32];
    logic         model_ack;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] read_reg(input int unsigned r);
        logic [W-1:0] v;
        for (int unsigned b = 0; b < W; b++) v[b] = bus.columns[b][r];
        return v;
    endfunction

    task automatic check_all(input string where);
        for (int unsigned r = 0; r < 32; r++)
            check($sformatf("%s reg%0d", where, r), read_reg(r), model[r]);
        check($sformatf("%s ack", where), {63'd0, bus.wr_ack}, {63'd0, model_ack});
    endtask

    task automatic clear_model();
        for (int unsigned r = 0; r < 32; r++) model[r] = '0;
        model_ack = 1'b0;
    endtask

    // Drive one cycle of stimulus (called right after a falling edge), apply the
    // architectural write rule to the model at the rising edge, check at the next fall.
    task automatic cycle(input logic en, input logic [4:0] addr, input logic [W-1:0] data,
                         input string where);
        bus.wr_en   = en;
        bus.wr_addr = addr;
        bus.wr_data = data;
        #1;
        check_all({where, " pre"});
        @(posedge clk);
        if (reset_n) begin
            if (en && addr != 5'd31) model[addr] = data;
            model_ack = en && addr != 5'd31;
        end
        @(negedge clk);
        check_all(where);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_model();

        // Write attempted while reset is held is ignored.
        reset_n     = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = '1;
        @(posedge clk);
        @(negedge clk);
        check_all("in_reset");
        reset_n = 1'b1;

        cycle(1'b1, 5'd3, '1, "first_write");
        check("first_write ack", {63'd0, bus.wr_ack}, 64'd1);
        cycle(1'b0, 5'd3, '0, "ack_drop");

        for (int unsigned i = 0; i < 31; i++)
            cycle(1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, "sweep");
        cycle(1'b0, 5'd0, '0, "sweep_idle");

        cycle(1'b1, 5'd31, 64'hDEAD_BEEF_0000_0001, "zero_reg");

        for (int unsigned k = 0; k < 4; k++)
            cycle(1'b0, 5'd5, 64'h1234, "gated");

        cycle(1'b1, 5'd7, 64'hA, "b2b_a");
        cycle(1'b1, 5'd7, 64'hB, "b2b_b");
        cycle(1'b1, 5'd8, 64'hC, "b2b_c");
        cycle(1'b0, 5'd0, '0, "b2b_idle");

        // Asynchronous reset pulse between edges.
        cycle(1'b1, 5'd2, 64'h55, "load2");
        bus.wr_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        clear_model();
        check_all("async_reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int unsigned k = 0; k < 300; k++) begin
            logic [W-1:0] d;
            d = {$urandom(), $urandom()};
            cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), d, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_array.md
# regfile_array

Storage stage of the register file: 32 registers of `WIDTH` bits, each with a one-hot write decoder. It presents its contents as a bit-transposed bus, so each 32:1 read multiplexer downstream receives one 32-bit column, one bit per register, and selects a bit with the 5-bit read address. Register 31 is the hardwired zero register.

## Interface
Parameters:
- `WIDTH`, default 64: data width of each register and the number of output columns.

Ports:
- `clk` input 1: single clock for all state; rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write enable, sampled at rising `clk`.
- `wr_addr` input 5: destination register index, 0..31.
- `wr_data` input `WIDTH`: write data.
- `columns` output `WIDTH`×32, packed `[WIDTH-1:0][31:0]`. `columns[b][r]` = bit b of register r.
- `wr_ack` output 1: registered pulse, high for one cycle after an accepted write to registers 0..30.

## Operation
- The decoder (enabled by `wr_en`) drives `wr_addr` to a 32-bit one-hot `wr_sel`. All zeros when `wr_en`=0.
- Register r, for r in 0..30:
  - If `wr_sel[r]`=1 at the rising edge, it loads `wr_data`.
  - Otherwise it holds.
- Register 31 has no storage, is never written, and drives constant 0 on every column.
  - `wr_en`=1 with `wr_addr`=31 is legal, has no effect, and gives `wr_ack`=0.
- Output `columns` is pure wiring from register state; there is no logic between the flops and the output.
- `wr_ack` is a flop:
  - It takes the value `wr_en && (wr_addr != 31)` at each rising edge.
- Only one write port exists, so write-write conflicts cannot occur.
- The read side is combinational downstream. This block has no read/write bypass.

## Timing
- Reset:
  - `reset_n`=0 clears registers 0..30 and `wr_ack` to 0 immediately, without waiting for a clock edge.
  - All `columns` read 0 during reset and after it.
- The last low→high transition of `reset_n` releases the block. A write presented at the first rising edge after release is accepted.
  - The integrator is responsible for synchronising deassertion.
- If reset asserts in the middle of operation, any write in flight in that cycle is lost.
  - The register returns to 0, not to `wr_data`.
- Write latency:
  - `wr_data` appears on `columns[*][wr_addr]` within clock-to-q after the rising edge that samples `wr_en`=1.
  - A read of the same register in the same cycle as the write returns the old value.
  - The new value is visible from the next cycle onward.
- `wr_ack` rises on the same edge that updates the register and falls one cycle later, unless a further write is accepted.
- Back-to-back writes (one per cycle, to any addresses, including the same address) are all accepted. The last one wins.
- Changes on `wr_addr` or `wr_data` while `wr_en`=0 have no effect.

## Structure
- Package `regfile_pkg`:
  - `NUM_REGS`=32, `ADDR_W`=5, `ZERO_REG`=5'd31.
  - `typedef logic [ADDR_W-1:0] reg_addr_t`.
- Sub-module `decoder_5to32` (enable, 5-bit address in, 32-bit one-hot out).
  - Built hierarchically from 2:4 and 3:8 decoders, mirroring the structure of the hierarchical mux tree.
  - Instantiated once.
- Storage:
  - A `generate` loop over r=0..30 instantiates `WIDTH`-bit enabled registers.
  - Each register is built from a D flip-flop with asynchronous clear plus a 2:1 hold/load mux per bit.
  - A second `generate` loop over b transposes the stored words into `columns`.

## Test plan
- Reset: with `reset_n`=0 and `wr_en`=1, `wr_addr`=3, `wr_data`=64'hFFFF_FFFF_FFFF_FFFF at a rising edge → all `columns`=0 and `wr_ack`=0. After release, the same write gives `columns[b][3]`=1 for all b and `wr_ack`=1 for one cycle.
- Sweep: write i×64'h0101_0101_0101_0101 to register i for i=0..30, then read every `columns[b][i]` → each bit matches the written word. `columns[*][31]`=0 throughout.
- Zero register: write 64'hDEAD_BEEF_0000_0001 to address 31 → `columns[*][31]` stays 0, no other register changes, `wr_ack`=0.
- Enable gating: set `wr_en`=0 with address 5, data 64'h1234 for 4 cycles → register 5 keeps its previous value and `wr_ack` stays 0.
- Back-to-back: write 64'hA to register 7, then 64'hB to register 7, then 64'hC to register 8, on consecutive cycles → register 7 ends at 64'hB, register 8 ends at 64'hC, and `wr_ack` is high for 3 consecutive cycles.
- Asynchronous reset mid-operation: after loading register 2 with 64'h55, pulse `reset_n` low between clock edges → register 2 reads 0 before the next rising edge.
